// File: rtl/fir_result_reader.sv
// ---------------------------------------------------------------------------
// fir_result_reader
//
// Sweeps the direct-form and transposed-form FIR output memories in lockstep,
// streams every address / word pair over a valid/ready handshake, flags words
// where the two filter results differ and reports an overall pass/fail.
//
// Parameters
//   START_ADDR : first word address read (0..255)
//   COUNT      : number of words read (1..256)
//   DW         : memory data width
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle sweep request (honoured in IDLE or DONE)
//   busy, done, pass  : sweep status; pass valid while done
//   mem_ra, mem_ca    : row / column address (addr[7:2], addr[1:0])
//   mem_nce, mem_nwrt : active-low chip / write enable (never writes)
//   dod, dot          : read data from direct / transposed memory
//   out_valid/ready   : result handshake
//   out_addr, out_direct, out_trans, out_mismatch : presented word
//   mismatch_cnt      : number of accepted mismatching words
// ---------------------------------------------------------------------------
module fir_result_reader #(
    parameter int START_ADDR = 0,
    parameter int COUNT      = 256,
    parameter int DW         = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [5:0]    mem_ra,
    output logic [1:0]    mem_ca,
    output logic          mem_nce,
    output logic          mem_nwrt,
    input  logic [DW-1:0] dod,
    input  logic [DW-1:0] dot,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_addr,
    output logic [DW-1:0] out_direct,
    output logic [DW-1:0] out_trans,
    output logic          out_mismatch,
    output logic [8:0]    mismatch_cnt
);

    localparam logic [7:0] FIRST_ADDR = 8'(START_ADDR);
    localparam logic [8:0] LAST_WORD  = 9'(COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      addr_reg, addr_next;
    logic [8:0]      word_reg, word_next;
    logic [8:0]      mm_cnt_reg, mm_cnt_next;
    logic [7:0]      out_addr_reg, out_addr_next;
    logic [DW-1:0]   out_direct_reg, out_direct_next;
    logic [DW-1:0]   out_trans_reg, out_trans_next;
    logic            out_mm_reg, out_mm_next;

    // Per-bit difference of the two memory words; any set bit is a mismatch.
    logic [DW-1:0]   diff_bits;
    logic            word_differs;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_diff
            assign diff_bits[gi] = dod[gi] ^ dot[gi];
        end
    endgenerate

    assign word_differs = |diff_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            word_reg       <= '0;
            mm_cnt_reg     <= '0;
            out_addr_reg   <= '0;
            out_direct_reg <= '0;
            out_trans_reg  <= '0;
            out_mm_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            word_reg       <= word_next;
            mm_cnt_reg     <= mm_cnt_next;
            out_addr_reg   <= out_addr_next;
            out_direct_reg <= out_direct_next;
            out_trans_reg  <= out_trans_next;
            out_mm_reg     <= out_mm_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        word_next       = word_reg;
        mm_cnt_next     = mm_cnt_reg;
        out_addr_next   = out_addr_reg;
        out_direct_next = out_direct_reg;
        out_trans_next  = out_trans_reg;
        out_mm_next     = out_mm_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                // Presented word fields are kept from the last sweep until
                // the next capture overwrites them.
                if (start) begin
                    addr_next   = FIRST_ADDR;
                    word_next   = '0;
                    mm_cnt_next = '0;
                    state_next  = S_READ;
                end
            end
            S_READ: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Read data belongs to the address issued in the READ cycle,
                // which addr_reg still holds.
                out_direct_next = dod;
                out_trans_next  = dot;
                out_addr_next   = addr_reg;
                out_mm_next     = word_differs;
                state_next      = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (out_mm_reg) begin
                        mm_cnt_next = mm_cnt_reg + 9'd1;
                    end
                    if (word_reg == LAST_WORD) begin
                        state_next = S_DONE;
                    end else begin
                        addr_next  = addr_reg + 8'd1;   // wraps modulo 256
                        word_next  = word_reg + 9'd1;
                        state_next = S_READ;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_reg == S_READ) || (state_reg == S_CAPTURE) ||
                          (state_reg == S_PRESENT);
    assign done         = (state_reg == S_DONE);
    assign pass         = done && (mm_cnt_reg == 9'd0);
    assign out_valid    = (state_reg == S_PRESENT);
    assign mem_nce      = (state_reg != S_READ);
    assign mem_nwrt     = 1'b1;
    assign mem_ra       = addr_reg[7:2];
    assign mem_ca       = addr_reg[1:0];
    assign out_addr     = out_addr_reg;
    assign out_direct   = out_direct_reg;
    assign out_trans    = out_trans_reg;
    assign out_mismatch = out_mm_reg;
    assign mismatch_cnt = mm_cnt_reg;

endmodule

// File: tb/tb_fir_result_reader.sv
// ---------------------------------------------------------------------------
// tb_fir_result_reader
//
// Bench for fir_result_reader. Two instances share one pair of behavioural
// output memories: the default full sweep (0, 256) and a wrapping sweep
// (250, 10). Expected words are queued when a sweep is started and checked
// as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_fir_result_reader;

    localparam int DW = 22;

    typedef struct packed {
        logic [7:0]    a;
        logic [DW-1:0] d;
        logic [DW-1:0] t;
        logic          mm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // main instance
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [5:0]    mem_ra;
    logic [1:0]    mem_ca;
    logic          mem_nce, mem_nwrt;
    logic [DW-1:0] dod = '0, dot = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_addr;
    logic [DW-1:0] out_direct, out_trans;
    logic          out_mismatch;
    logic [8:0]    mismatch_cnt;

    // wrapping instance
    logic          start_w = 1'b0;
    logic          busy_w, done_w, pass_w;
    logic [5:0]    mem_ra_w;
    logic [1:0]    mem_ca_w;
    logic          mem_nce_w, mem_nwrt_w;
    logic [DW-1:0] dod_w = '0, dot_w = '0;
    logic          out_valid_w;
    logic          out_ready_w = 1'b1;
    logic [7:0]    out_addr_w;
    logic [DW-1:0] out_direct_w, out_trans_w;
    logic          out_mismatch_w;
    logic [8:0]    mismatch_cnt_w;

    logic [DW-1:0] mem_d [256];
    logic [DW-1:0] mem_t [256];

    exp_t q_main[$];
    exp_t q_w[$];
    exp_t e_main, e_w;

    int n_checks = 0;
    int n_pass   = 0;
    int nce_cnt  = 0;
    int stall_cnt = 0;
    int mm_seen  = 0;
    bit bp_en    = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0]    sv_addr;
    logic [DW-1:0] sv_d, sv_t;
    logic          sv_mm;

    fir_result_reader #(.START_ADDR(0), .COUNT(256), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .mem_ra(mem_ra), .mem_ca(mem_ca), .mem_nce(mem_nce),
        .mem_nwrt(mem_nwrt), .dod(dod), .dot(dot), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_direct(out_direct),
        .out_trans(out_trans), .out_mismatch(out_mismatch),
        .mismatch_cnt(mismatch_cnt)
    );

    fir_result_reader #(.START_ADDR(250), .COUNT(10), .DW(DW)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .busy(busy_w), .done(done_w),
        .pass(pass_w), .mem_ra(mem_ra_w), .mem_ca(mem_ca_w),
        .mem_nce(mem_nce_w), .mem_nwrt(mem_nwrt_w), .dod(dod_w), .dot(dot_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_addr(out_addr_w), .out_direct(out_direct_w),
        .out_trans(out_trans_w), .out_mismatch(out_mismatch_w),
        .mismatch_cnt(mismatch_cnt_w)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid the cycle after the request.
    always @(posedge clk) begin
        if (!mem_nce && mem_nwrt) begin
            dod <= mem_d[{mem_ra, mem_ca}];
            dot <= mem_t[{mem_ra, mem_ca}];
        end
        if (!mem_nce_w && mem_nwrt_w) begin
            dod_w <= mem_d[{mem_ra_w, mem_ca_w}];
            dot_w <= mem_t[{mem_ra_w, mem_ca_w}];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // err_mode 0: clean, 1: errors at 5/100/255, 2: error at 5
    task automatic fill(input int err_mode);
        for (int a = 0; a < 256; a++) begin
            mem_d[a] = DW'(a * 3);
            mem_t[a] = DW'(a * 3);
            if ((err_mode == 1 && (a == 5 || a == 100 || a == 255)) ||
                (err_mode == 2 && a == 5)) begin
                mem_t[a] = DW'(a * 3) ^ DW'(22'h2A5);
            end
        end
    endtask

    task automatic push_words(input int first, input int n, input bit to_w);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.a  = 8'((first + i) % 256);
            e.d  = mem_d[(first + i) % 256];
            e.t  = mem_t[(first + i) % 256];
            e.mm = (e.d != e.t);
            if (to_w) q_w.push_back(e);
            else      q_main.push_back(e);
        end
    endtask

    // Called at posedge+1; the edge inside is the one that samples start.
    task automatic start_main(input int n);
        nce_cnt   = 0;
        stall_cnt = 0;
        mm_seen   = 0;
        push_words(0, n, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_nce_low", 64'(mem_nce), 64'd0);
        check("start_addr", 64'({mem_ra, mem_ca}), 64'd0);
        check("start_mm_cleared", 64'(mismatch_cnt), 64'd0);
    endtask

    task automatic wait_done_main(output int cyc);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    // Ready pattern 1-0-0-1 repeating when back-pressure is enabled.
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Main scoreboard / stability monitor.
    always @(negedge clk) begin
        if (!mem_nce) nce_cnt++;
        if (out_valid) begin
            if (stall_prev) begin
                check("stall_addr", 64'(out_addr), 64'(sv_addr));
                check("stall_direct", 64'(out_direct), 64'(sv_d));
                check("stall_trans", 64'(out_trans), 64'(sv_t));
                check("stall_mm", 64'(out_mismatch), 64'(sv_mm));
            end
            if (out_ready) begin
                stall_prev = 1'b0;
                if (q_main.size() == 0) begin
                    check("main_extra_word", 64'(out_addr), 64'hFFFF);
                end else begin
                    e_main = q_main.pop_front();
                    check("main_addr", 64'(out_addr), 64'(e_main.a));
                    check("main_direct", 64'(out_direct), 64'(e_main.d));
                    check("main_trans", 64'(out_trans), 64'(e_main.t));
                    check("main_mm", 64'(out_mismatch), 64'(e_main.mm));
                    if (out_mismatch) mm_seen++;
                    $display("main word addr=%0d direct=%0h trans=%0h mm=%0d",
                             out_addr, out_direct, out_trans, out_mismatch);
                end
            end else begin
                stall_prev = 1'b1;
                stall_cnt++;
                sv_addr = out_addr;
                sv_d    = out_direct;
                sv_t    = out_trans;
                sv_mm   = out_mismatch;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Wrapping-instance scoreboard.
    always @(negedge clk) begin
        if (out_valid_w && out_ready_w) begin
            if (q_w.size() == 0) begin
                check("wrap_extra_word", 64'(out_addr_w), 64'hFFFF);
            end else begin
                e_w = q_w.pop_front();
                check("wrap_addr", 64'(out_addr_w), 64'(e_w.a));
                check("wrap_direct", 64'(out_direct_w), 64'(e_w.d));
                check("wrap_mm", 64'(out_mismatch_w), 64'(e_w.mm));
                $display("wrap word addr=%0d direct=%0h trans=%0h mm=%0d",
                         out_addr_w, out_direct_w, out_trans_w, out_mismatch_w);
            end
        end
    end

    initial begin
        int cyc;
        bit found;

        fill(0);
        repeat (3) @(posedge clk);
        #1;
        // Reset state (rst still high)
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_mm", 64'(out_mismatch), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_direct", 64'(out_direct), 64'd0);
        check("rst_trans", 64'(out_trans), 64'd0);
        check("rst_mm_cnt", 64'(mismatch_cnt), 64'd0);
        check("rst_nce", 64'(mem_nce), 64'd1);
        check("rst_nwrt", 64'(mem_nwrt), 64'd1);
        check("rst_ra_ca", 64'({mem_ra, mem_ca}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: identical contents, full-speed sweep
        start_main(256);
        wait_done_main(cyc);
        check("t1_cycles", 64'(cyc), 64'd768);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_mm_cnt", 64'(mismatch_cnt), 64'd0);
        check("t1_nce_pulses", 64'(nce_cnt), 64'd256);
        check("t1_queue_empty", 64'(q_main.size()), 64'd0);

        // 2: injected errors at 5, 100, 255
        fill(1);
        start_main(256);
        wait_done_main(cyc);
        check("t2_cycles", 64'(cyc), 64'd768);
        check("t2_mm_cnt", 64'(mismatch_cnt), 64'd3);
        check("t2_mm_seen", 64'(mm_seen), 64'd3);
        check("t2_pass", 64'(pass), 64'd0);
        check("t2_queue_empty", 64'(q_main.size()), 64'd0);

        // 3: restart from failing DONE, clean data, back-pressure
        fill(0);
        bp_en = 1'b1;
        start_main(256);
        wait_done_main(cyc);
        bp_en = 1'b0;
        check("t3_cycles", 64'(cyc), 64'(768 + stall_cnt));
        check("t3_stalls_seen", 64'(stall_cnt > 0), 64'd1);
        check("t3_nce_pulses", 64'(nce_cnt), 64'd256);
        check("t3_pass", 64'(pass), 64'd1);
        check("t3_mm_cnt", 64'(mismatch_cnt), 64'd0);
        check("t3_queue_empty", 64'(q_main.size()), 64'd0);

        // 4: wrapping sweep 250..255, 0..3 with an ignored mid-sweep start
        push_words(250, 10, 1'b1);
        start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        cyc = 0;
        while (!done_w && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            start_w = (cyc == 5);
        end
        start_w = 1'b0;
        check("t4_done", 64'(done_w), 64'd1);
        check("t4_cycles", 64'(cyc), 64'd30);
        check("t4_pass", 64'(pass_w), 64'd1);
        check("t4_queue_empty", 64'(q_w.size()), 64'd0);

        // 5: reset while word 40 is presented
        fill(2);
        start_main(256);
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            found = out_valid && (out_addr == 8'd40);
        end
        check("t5_word40_reached", 64'(found), 64'd1);
        check("t5_pre_mm_cnt", 64'(mismatch_cnt), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_nce", 64'(mem_nce), 64'd1);
        check("t5_mm_cnt", 64'(mismatch_cnt), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        q_main.delete();
        @(posedge clk); #1;
        fill(0);
        start_main(256);
        wait_done_main(cyc);
        check("t5_cycles", 64'(cyc), 64'd768);
        check("t5_pass", 64'(pass), 64'd1);
        check("t5_queue_empty", 64'(q_main.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
